sram_req_ctrl: RTL and testbench

- Initiator side of the team's single-port SRAM interface; drives the `sram_if` slave modport (en/wen/bm/addr/dat out, dat back in).
- Converts a valid/ready request channel into SRAM accesses. Read data returns in order through a valid/ready response channel with a small buffer.
- Optionally zero-fills the whole macro after reset before it accepts any traffic.
- Sits between bus bridges (APB/AXI slaves) and the SRAM macro.

---
 rtl/sram_req_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl
//   Initiator side of the single-port SRAM interface. Turns a valid/ready
//   request channel into SRAM accesses (one access per accepted request, in
//   the same cycle) and returns read data, in order, through a valid/ready
//   response channel backed by a small FIFO. When INIT_EN=1 the whole macro
//   is zero-filled after reset before any request is accepted.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_we_i              1 = write, 0 = read
//   req_be_i              byte enables for writes (ignored for reads)
//   req_addr_i            word address
//   req_wdata_i           write data
//   rsp_valid_o/ready_i   read response handshake
//   rsp_rdata_o           read data (registered, from buffer head)
//   init_done_o           high once the controller is in RUN
//   sram_en_o/wen_o       SRAM access enable / write enable
//   sram_bm_o             byte write mask (1 = byte written)
//   sram_addr_o           SRAM address
//   sram_dat_o            SRAM write data
//   sram_dat_i            SRAM read data, valid the cycle after a read
module sram_req_ctrl #(
    parameter int BIT_WIDTH  = 64,
    parameter int WORD_DEPTH = 512,
    parameter int RSP_DEPTH  = 2,
    parameter int INIT_EN    = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [BIT_WIDTH/8-1:0]        req_be_i,
    input  logic [$clog2(WORD_DEPTH)-1:0] req_addr_i,
    input  logic [BIT_WIDTH-1:0]          req_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [BIT_WIDTH-1:0]          rsp_rdata_o,
    output logic                          init_done_o,
    output logic                          sram_en_o,
    output logic                          sram_wen_o,
    output logic [BIT_WIDTH/8-1:0]        sram_bm_o,
    output logic [$clog2(WORD_DEPTH)-1:0] sram_addr_o,
    output logic [BIT_WIDTH-1:0]          sram_dat_o,
    input  logic [BIT_WIDTH-1:0]          sram_dat_i
);

    localparam int AW = $clog2(WORD_DEPTH);
    localparam int BW = BIT_WIDTH / 8;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_DEPTH - 1);
    localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(RSP_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  init_cnt;

    // Read issued to the SRAM last cycle; its data is on sram_dat_i now.
    logic           rd_vld_p1;

    logic [BIT_WIDTH-1:0] rsp_buf [RSP_DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;

    logic           push;
    logic           pop;
    logic           rd_acc;
    logic [CW:0]    occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. RUN is only left through reset.
    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_cnt == LAST_ADDR) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + AW'(1);
        end
    end

    // Credits: entries already held or about to land, minus the one leaving
    // this cycle. Depends combinationally on rsp_ready_i so a full buffer
    // can pop and accept a new read in the same cycle.
    assign pop = rsp_valid_o & rsp_ready_i;
    assign occ = {1'b0, count} + {{CW{1'b0}}, rd_vld_p1} - {{CW{1'b0}}, pop};

    // FSM: outputs and SRAM drive
    always_comb begin
        init_done_o = 1'b0;
        req_ready_o = 1'b0;
        sram_en_o   = 1'b0;
        sram_wen_o  = 1'b0;
        sram_bm_o   = '0;
        sram_addr_o = '0;
        sram_dat_o  = '0;
        case (state)
            ST_INIT: begin
                sram_en_o   = 1'b1;
                sram_wen_o  = 1'b1;
                sram_bm_o   = '1;
                sram_addr_o = init_cnt;
            end
            ST_RUN: begin
                init_done_o = 1'b1;
                // Writes produce no response, so they never need a credit.
                req_ready_o = req_we_i | (occ < OCC_LIMIT);
                sram_en_o   = req_valid_i & req_ready_o;
                if (sram_en_o) begin
                    sram_wen_o  = req_we_i;
                    // Reads write nothing, so their mask is cleared.
                    sram_bm_o   = req_we_i ? req_be_i : {BW{1'b0}};
                    sram_addr_o = req_addr_i;
                    sram_dat_o  = req_wdata_i;
                end
            end
            default: ;
        endcase
    end

    assign rd_acc = req_valid_i & req_ready_o & ~req_we_i;

    // ---------------------------------------------------------------
    // Stage p1: SRAM read data captured into the response buffer tail
    // ---------------------------------------------------------------
    assign push = rd_vld_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld_p1 <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            rd_vld_p1 <= rd_acc;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rsp_buf[tail] <= sram_dat_i;
        end
    end

    // ---------------------------------------------------------------
    // Stage p2: response presented from the buffer head
    // ---------------------------------------------------------------
    assign rsp_valid_o = (count != '0);
    assign rsp_rdata_o = rsp_buf[head];

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

    localparam int BIT_WIDTH  = 64;
    localparam int WORD_DEPTH = 8;
    localparam int RSP_DEPTH  = 2;
    localparam int AW         = 3;
    localparam int BW         = 8;

    logic                 clk;
    logic                 rst_i;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [BW-1:0]        req_be_i;
    logic [AW-1:0]        req_addr_i;
    logic [BIT_WIDTH-1:0] req_wdata_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [BIT_WIDTH-1:0] rsp_rdata_o;
    logic                 init_done_o;
    logic                 sram_en_o;
    logic                 sram_wen_o;
    logic [BW-1:0]        sram_bm_o;
    logic [AW-1:0]        sram_addr_o;
    logic [BIT_WIDTH-1:0] sram_dat_o;
    logic [BIT_WIDTH-1:0] sram_dat_i;

    sram_req_ctrl #(
        .BIT_WIDTH(BIT_WIDTH), .WORD_DEPTH(WORD_DEPTH),
        .RSP_DEPTH(RSP_DEPTH), .INIT_EN(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_be_i(req_be_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .init_done_o(init_done_o),
        .sram_en_o(sram_en_o), .sram_wen_o(sram_wen_o),
        .sram_bm_o(sram_bm_o), .sram_addr_o(sram_addr_o),
        .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    logic [BIT_WIDTH-1:0] golden [WORD_DEPTH];

    // SRAM macro: registered read, byte-masked write.
    logic [BIT_WIDTH-1:0] sram_mem [WORD_DEPTH];
    always @(posedge clk) begin
        if (sram_en_o) begin
            if (sram_wen_o) begin
                for (int b = 0; b < BW; b++)
                    if (sram_bm_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_dat_o[8*b +: 8];
            end else begin
                sram_dat_i <= sram_mem[sram_addr_o];
            end
        end
    end

    // Reference model: memory contents as seen by requests, and the list of
    // outstanding reads with the cycle each was accepted in.
    typedef struct {
        logic [BIT_WIDTH-1:0] data;
        int                   t;
    } rsp_t;
    rsp_t                 exp_q [$];
    logic [BIT_WIDTH-1:0] ref_mem [WORD_DEPTH];

    always @(posedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            for (int i = 0; i < WORD_DEPTH; i++) ref_mem[i] = '0;
        end else begin
            if (rsp_valid_o && rsp_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (req_valid_i && req_ready_o) begin
                if (req_we_i) begin
                    for (int b = 0; b < BW; b++)
                        if (req_be_i[b]) ref_mem[req_addr_i][8*b +: 8] = req_wdata_i[8*b +: 8];
                end else begin
                    exp_q.push_back('{data: ref_mem[req_addr_i], t: cyc});
                end
            end
        end
        cyc++;
    end

    // Running protocol monitor while in RUN traffic phases.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        int   held;
        if (chk_en && !rst_i) begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
            held      = exp_q.size() - ((exp_valid && rsp_ready_i) ? 1 : 0);
            exp_ready = req_we_i || (held < RSP_DEPTH);
            n_checks++; if (rsp_valid_o !== exp_valid) begin n_fail++; $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid_o, exp_valid); end
            if (exp_valid) begin
                n_checks++; if (rsp_rdata_o !== exp_q[0].data) begin n_fail++; $display("FAIL mon_rsp_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata_o, exp_q[0].data); end
            end
            n_checks++; if (req_ready_o !== exp_ready) begin n_fail++; $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_ready); end
            n_checks++; if (sram_en_o !== (req_valid_i & exp_ready)) begin n_fail++; $display("FAIL mon_sram_en cyc=%0d got=%b exp=%b", cyc, sram_en_o, req_valid_i & exp_ready); end
            if (req_valid_i && exp_ready) begin
                n_checks++; if (sram_wen_o !== req_we_i || sram_addr_o !== req_addr_i) begin n_fail++; $display("FAIL mon_sram_cmd cyc=%0d got wen=%b addr=%0d exp wen=%b addr=%0d", cyc, sram_wen_o, sram_addr_o, req_we_i, req_addr_i); end
                if (req_we_i) begin
                    n_checks++; if (sram_bm_o !== req_be_i || sram_dat_o !== req_wdata_i) begin n_fail++; $display("FAIL mon_sram_wr cyc=%0d got bm=%h dat=%h exp bm=%h dat=%h", cyc, sram_bm_o, sram_dat_o, req_be_i, req_wdata_i); end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_init();
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_be_i = '0;
        req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
        repeat (2) step();
        rst_i = 1'b0;
        // A write is offered throughout the fill; it must wait for RUN.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = '1;
        for (int c = 0; c <= WORD_DEPTH; c++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL init_rsp_valid c=%0d got=%b exp=0", c, rsp_valid_o); end
            if (c < WORD_DEPTH) begin
                n_checks++; if (sram_en_o !== 1'b1) begin n_fail++; $display("FAIL init_en c=%0d got=%b exp=1", c, sram_en_o); end
                n_checks++; if (sram_wen_o !== 1'b1) begin n_fail++; $display("FAIL init_wen c=%0d got=%b exp=1", c, sram_wen_o); end
                n_checks++; if (sram_bm_o !== 8'hFF) begin n_fail++; $display("FAIL init_bm c=%0d got=%h exp=ff", c, sram_bm_o); end
                n_checks++; if (sram_dat_o !== 64'h0) begin n_fail++; $display("FAIL init_dat c=%0d got=%h exp=0", c, sram_dat_o); end
                n_checks++; if (sram_addr_o !== AW'(c)) begin n_fail++; $display("FAIL init_addr c=%0d got=%0d exp=%0d", c, sram_addr_o, c); end
                n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL init_ready c=%0d got=%b exp=0", c, req_ready_o); end
                n_checks++; if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL init_done_early c=%0d got=%b exp=0", c, init_done_o); end
            end else begin
                n_checks++; if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL init_done c=%0d got=%b exp=1", c, init_done_o); end
                n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL run_ready c=%0d got=%b exp=1", c, req_ready_o); end
            end
            step();
        end
        req_valid_i = 1'b0;
    endtask

    task automatic test_write_read();
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = 8'h0F; req_addr_i = 3'd3;
        req_wdata_i = 64'h1122334455667788;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b1 || sram_en_o !== 1'b1) begin n_fail++; $display("FAIL wr_accept got ready=%b en=%b exp 1 1", req_ready_o, sram_en_o); end
        n_checks++; if (sram_bm_o !== 8'h0F || sram_addr_o !== 3'd3) begin n_fail++; $display("FAIL wr_drive got bm=%h addr=%0d exp 0f 3", sram_bm_o, sram_addr_o); end
        step();
        req_we_i = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b1 || sram_en_o !== 1'b1 || sram_wen_o !== 1'b0) begin n_fail++; $display("FAIL rd_accept got ready=%b en=%b wen=%b exp 1 1 0", req_ready_o, sram_en_o, sram_wen_o); end
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_lat1 got=%b exp=0", rsp_valid_o); end
        step();
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rd_lat2 got=%b exp=1", rsp_valid_o); end
        n_checks++; if (rsp_rdata_o !== 64'h0000000055667788) begin n_fail++; $display("FAIL rd_data got=%h exp=0000000055667788", rsp_rdata_o); end
        step();
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_single got=%b exp=0", rsp_valid_o); end
        step();
    endtask

    task automatic test_back_to_back();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = '1; req_addr_i = AW'(i);
            req_wdata_i = {$urandom, $urandom};
            golden[i] = req_wdata_i;
            step();
        end
        for (int i = 0; i < 7; i++) begin
            req_valid_i = (i < 4); req_we_i = 1'b0; req_addr_i = AW'(i);
            @(negedge clk);
            if (i < 4) begin
                n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_ready_o); end
            end
            n_checks++; if (rsp_valid_o !== (i >= 2 && i < 6)) begin n_fail++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, rsp_valid_o, (i >= 2 && i < 6)); end
            if (i >= 2 && i < 6) begin
                n_checks++; if (rsp_rdata_o !== golden[i-2]) begin n_fail++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, rsp_rdata_o, golden[i-2]); end
            end
            step();
        end
        req_valid_i = 1'b0;
    endtask

    task automatic test_stall();
        logic [BIT_WIDTH-1:0] wd;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd0;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_rd0 got=%b exp=1", req_ready_o); end
        step(); req_addr_i = 3'd1;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_rd1 got=%b exp=1", req_ready_o); end
        step(); req_addr_i = 3'd2;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b0 || sram_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_rd2 got ready=%b en=%b exp 0 0", req_ready_o, sram_en_o); end
        step();
        wd = {$urandom, $urandom};
        req_we_i = 1'b1; req_addr_i = 3'd5; req_be_i = '1; req_wdata_i = wd;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b1 || sram_en_o !== 1'b1) begin n_fail++; $display("FAIL stall_wr got ready=%b en=%b exp 1 1", req_ready_o, sram_en_o); end
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== golden[0]) begin n_fail++; $display("FAIL stall_hold1 got v=%b d=%h exp 1 %h", rsp_valid_o, rsp_rdata_o, golden[0]); end
        step();
        golden[5] = wd;
        req_we_i = 1'b0; req_addr_i = 3'd2;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_rd2_again got=%b exp=0", req_ready_o); end
        n_checks++; if (rsp_rdata_o !== golden[0]) begin n_fail++; $display("FAIL stall_hold2 got=%h exp=%h", rsp_rdata_o, golden[0]); end
        step();
        rsp_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready_o !== 1'b1 || sram_en_o !== 1'b1) begin n_fail++; $display("FAIL stall_pop_accept got ready=%b en=%b exp 1 1", req_ready_o, sram_en_o); end
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== golden[0]) begin n_fail++; $display("FAIL stall_rsp0 got v=%b d=%h exp 1 %h", rsp_valid_o, rsp_rdata_o, golden[0]); end
        step();
        req_valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid_o !== (k < 3)) begin n_fail++; $display("FAIL stall_valid k=%0d got=%b exp=%b", k, rsp_valid_o, (k < 3)); end
            if (k < 3) begin
                n_checks++; if (rsp_rdata_o !== golden[k]) begin n_fail++; $display("FAIL stall_rsp k=%0d got=%h exp=%h", k, rsp_rdata_o, golden[k]); end
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_we_i    = $urandom_range(0, 1);
            req_be_i    = BW'($urandom);
            req_addr_i  = AW'($urandom_range(0, WORD_DEPTH - 1));
            req_wdata_i = {$urandom, $urandom};
            rsp_ready_i = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (4) step();
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain got v=%b outstanding=%0d exp 0 0", rsp_valid_o, exp_q.size()); end
        step();
    endtask

    task automatic test_reset_mid();
        chk_en = 1'b0;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd0;
        step(); req_addr_i = 3'd1;
        step(); req_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", rsp_valid_o); end
        rst_i = 1'b1;
        @(posedge clk); #1; rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_stale c=%0d got=%b exp=0", c, rsp_valid_o); end
            n_checks++; if (sram_en_o !== 1'b1 || sram_addr_o !== AW'(c)) begin n_fail++; $display("FAIL rst_init1 c=%0d got en=%b addr=%0d exp 1 %0d", c, sram_en_o, sram_addr_o, c); end
            if (c < 5) step();
        end
        rst_i = 1'b1;
        @(posedge clk); #1; rst_i = 1'b0;
        for (int c = 0; c <= WORD_DEPTH; c++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst2_valid c=%0d got=%b exp=0", c, rsp_valid_o); end
            if (c < WORD_DEPTH) begin
                n_checks++; if (sram_en_o !== 1'b1 || sram_addr_o !== AW'(c) || init_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_init2 c=%0d got en=%b addr=%0d done=%b exp 1 %0d 0", c, sram_en_o, sram_addr_o, init_done_o, c); end
            end else begin
                n_checks++; if (init_done_o !== 1'b1 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_run c=%0d got done=%b ready=%b exp 1 1", c, init_done_o, req_ready_o); end
            end
            step();
        end
        chk_en = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 3'd3;
        step(); req_valid_i = 1'b0;
        step();
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h0) begin n_fail++; $display("FAIL rst_zero_fill got v=%b d=%h exp 1 0", rsp_valid_o, rsp_rdata_o); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_init();
        chk_en = 1'b1;
        test_write_read();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
